fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of instruction decode. Owns the PC, issues single-outstanding

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/rvalid handshake plus the valid/stall path to decode.
// The master modport is the fetch unit; the slave modport is memory/decode/later stages.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rvalid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        instr_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, pc_plus2, instr_valid, halted,
    input  imem_rdata, imem_rvalid, instr_stall, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, pc_plus2, instr_valid, halted,
    output imem_rdata, imem_rvalid, instr_stall, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single-outstanding imem requests, redirect and halt.
// Define FETCH_PERF_CNT_EN to add saturating perf_instr_cnt / perf_wait_cnt outputs.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]     perf_instr_cnt,
  output logic [15:0]     perf_wait_cnt,
`endif
  fetch_unit_if.master    bus
);

  localparam logic [15:0] ResetPc = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {StReq, StWait, StValid, StHalt} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic [15:0] pc_plus2_q;
  logic        valid_q;
  logic        halted_q;
  logic        squash_q;

  logic        consume;
  logic [15:0] redirect_tgt;

  assign consume      = valid_q & ~bus.instr_stall;
  assign redirect_tgt = bus.redirect_pc & 16'hFFFE;

  assign bus.imem_req    = (state_q == StReq);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus2    = pc_plus2_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= ResetPc;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      pc_plus2_q <= 16'h0002;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StReq: begin
          // The request has already gone out, so a redirect can only mark it for dropping.
          state_q  <= StWait;
          squash_q <= bus.redirect;
          if (bus.redirect) pc_q <= redirect_tgt;
        end
        StWait: begin
          if (bus.redirect) begin
            pc_q <= redirect_tgt;
            if (bus.imem_rvalid) begin
              squash_q <= 1'b0;
              state_q  <= StReq;
            end else begin
              squash_q <= 1'b1;
            end
          end else if (bus.imem_rvalid) begin
            if (squash_q) begin
              squash_q <= 1'b0;
              state_q  <= StReq;
            end else begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= pc_q;
              pc_plus2_q <= pc_q + 16'd2;
              pc_q       <= pc_q + 16'd2;
              valid_q    <= 1'b1;
              state_q    <= StValid;
            end
          end
        end
        StValid: begin
          // Redirect beats halt: an HLT alongside a redirect is on the wrong path.
          if (bus.redirect) begin
            pc_q    <= redirect_tgt;
            valid_q <= 1'b0;
            state_q <= StReq;
          end else if (consume) begin
            valid_q <= 1'b0;
            if (bus.halt) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StReq;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_instr_q;
  logic [15:0] perf_wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_q <= 16'h0000;
      perf_wait_q  <= 16'h0000;
    end else if (state_q != StHalt) begin
      if (consume && perf_instr_q != 16'hFFFF) perf_instr_q <= perf_instr_q + 16'd1;
      if (state_q == StWait && perf_wait_q != 16'hFFFF) perf_wait_q <= perf_wait_q + 16'd1;
    end
  end

  assign perf_instr_cnt = perf_instr_q;
  assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run checked against
// a program-order model (expected PC sequence and memory image).
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] pic0, pwc0, pic1, pwc1;
  fetch_unit #(.RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst(rst0), .perf_instr_cnt(pic0), .perf_wait_cnt(pwc0), .bus(bus0.master)
  );
  fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
    .clk(clk), .rst(rst1), .perf_instr_cnt(pic1), .perf_wait_cnt(pwc1), .bus(bus1.master)
  );
`else
  fetch_unit #(.RESET_PC(16'h0000)) dut0 (.clk(clk), .rst(rst0), .bus(bus0.master));
  fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.master));
`endif

  // Memory image: address 0 holds 0x1234, everything else a scrambled address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    return (a ^ 16'hC3A5) + 16'h0101;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.imem_rvalid = 1'b0; bus0.imem_rdata = 16'h0000; bus0.instr_stall = 1'b0;
    bus0.redirect = 1'b0; bus0.redirect_pc = 16'h0000; bus0.halt = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    clear_inputs();
    bus1.imem_rvalid = 1'b0; bus1.imem_rdata = 16'h0000; bus1.instr_stall = 1'b0;
    bus1.redirect = 1'b0; bus1.redirect_pc = 16'h0000; bus1.halt = 1'b0;
    tick(); tick();
    total_cnt++;
    if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0000 || bus0.instr_valid !== 1'b0 ||
        bus0.halted !== 1'b0 || bus0.instr !== 16'h0000 || bus0.instr_pc !== 16'h0000)
      $display("FAIL reset_state: req=%b addr=%h valid=%b halted=%b instr=%h pc=%h want 1 0000 0 0 0000 0000",
               bus0.imem_req, bus0.imem_addr, bus0.instr_valid, bus0.halted, bus0.instr,
               bus0.instr_pc);
    else pass_cnt++;
    rst0 = 1'b0;
  endtask

  task automatic test_basic();
    total_cnt++;
    if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0000)
      $display("FAIL t1_first_req: req=%b addr=%h want 1 0000", bus0.imem_req, bus0.imem_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus0.imem_req !== 1'b0 || bus0.instr_valid !== 1'b0)
      $display("FAIL t1_wait: req=%b valid=%b want 0 0", bus0.imem_req, bus0.instr_valid);
    else pass_cnt++;
    bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 16'h1234;
    tick();
    bus0.imem_rvalid = 1'b0;
    total_cnt++;
    if (bus0.instr_valid !== 1'b1 || bus0.instr !== 16'h1234 || bus0.instr_pc !== 16'h0000 ||
        bus0.pc_plus2 !== 16'h0002)
      $display("FAIL t1_valid: valid=%b instr=%h pc=%h pc2=%h want 1 1234 0000 0002",
               bus0.instr_valid, bus0.instr, bus0.instr_pc, bus0.pc_plus2);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0002 || bus0.instr_valid !== 1'b0)
      $display("FAIL t1_next_req: req=%b addr=%h valid=%b want 1 0002 0",
               bus0.imem_req, bus0.imem_addr, bus0.instr_valid);
    else pass_cnt++;
    tick();
    bus0.imem_rvalid = 1'b1; bus0.imem_rdata = memf(16'h0002);
    tick();
    bus0.imem_rvalid = 1'b0;
  endtask

  task automatic test_stall();
    bus0.instr_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (bus0.instr_valid !== 1'b1 || bus0.instr !== memf(16'h0002) ||
          bus0.instr_pc !== 16'h0002 || bus0.imem_req !== 1'b0)
        $display("FAIL t2_hold%0d: valid=%b instr=%h pc=%h req=%b want 1 %h 0002 0", i,
                 bus0.instr_valid, bus0.instr, bus0.instr_pc, bus0.imem_req, memf(16'h0002));
      else pass_cnt++;
    end
    bus0.instr_stall = 1'b0;
    tick();
    total_cnt++;
    if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0004)
      $display("FAIL t2_req: req=%b addr=%h want 1 0004", bus0.imem_req, bus0.imem_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus0.imem_req !== 1'b0)
      $display("FAIL t2_single_req: req=%b want 0", bus0.imem_req);
    else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0041;
    tick();
    bus0.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 16'hBEEF; end
      total_cnt++;
      if (bus0.instr_valid !== 1'b0 || bus0.imem_req !== 1'b0)
        $display("FAIL t3_idle%0d: valid=%b req=%b want 0 0", i, bus0.instr_valid, bus0.imem_req);
      else pass_cnt++;
      tick();
    end
    bus0.imem_rvalid = 1'b0;
    total_cnt++;
    if (bus0.instr_valid !== 1'b0 || bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0040)
      $display("FAIL t3_req: valid=%b req=%b addr=%h want 0 1 0040",
               bus0.instr_valid, bus0.imem_req, bus0.imem_addr);
    else pass_cnt++;
    tick();
    bus0.imem_rvalid = 1'b1; bus0.imem_rdata = memf(16'h0040);
    tick();
    bus0.imem_rvalid = 1'b0;
    total_cnt++;
    if (bus0.instr_valid !== 1'b1 || bus0.instr_pc !== 16'h0040 || bus0.instr !== memf(16'h0040))
      $display("FAIL t3_valid: valid=%b pc=%h instr=%h want 1 0040 %h",
               bus0.instr_valid, bus0.instr_pc, bus0.instr, memf(16'h0040));
    else pass_cnt++;
  endtask

  task automatic test_halt();
    bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0010; bus0.instr_stall = 1'b1;
    tick();
    bus0.redirect = 1'b0; bus0.instr_stall = 1'b0;
    total_cnt++;
    if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0010 || bus0.instr_valid !== 1'b0)
      $display("FAIL t4_req: req=%b addr=%h valid=%b want 1 0010 0",
               bus0.imem_req, bus0.imem_addr, bus0.instr_valid);
    else pass_cnt++;
    tick();
    bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 16'hF000;
    tick();
    bus0.imem_rvalid = 1'b0; bus0.halt = 1'b1;
    tick();
    bus0.halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (bus0.halted !== 1'b1 || bus0.imem_req !== 1'b0 || bus0.instr_valid !== 1'b0)
        $display("FAIL t4_halted%0d: halted=%b req=%b valid=%b want 1 0 0", i,
                 bus0.halted, bus0.imem_req, bus0.instr_valid);
      else pass_cnt++;
      bus0.redirect = (i % 3 == 0); bus0.redirect_pc = 16'h0080;
      bus0.imem_rvalid = (i % 5 == 1);
      tick();
    end
    clear_inputs();
    rst0 = 1'b1;
    #1;
    total_cnt++;
    if (bus0.halted !== 1'b0 || bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0000)
      $display("FAIL t4_rst: halted=%b req=%b addr=%h want 0 1 0000",
               bus0.halted, bus0.imem_req, bus0.imem_addr);
    else pass_cnt++;
    tick();
    rst0 = 1'b0;
    // Stale response arriving while in REQ must be ignored.
    bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 16'hDEAD;
    tick();
    total_cnt++;
    if (bus0.instr_valid !== 1'b0)
      $display("FAIL t4_stale_rvalid: valid=%b want 0", bus0.instr_valid);
    else pass_cnt++;
    bus0.imem_rdata = memf(16'h0000);
    tick();
    bus0.imem_rvalid = 1'b0;
    total_cnt++;
    if (bus0.instr_valid !== 1'b1 || bus0.instr !== 16'h1234 || bus0.instr_pc !== 16'h0000)
      $display("FAIL t4_refetch: valid=%b instr=%h pc=%h want 1 1234 0000",
               bus0.instr_valid, bus0.instr, bus0.instr_pc);
    else pass_cnt++;
  endtask

  task automatic test_halt_redirect();
    bus0.halt = 1'b1; bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0080;
    tick();
    clear_inputs();
    total_cnt++;
    if (bus0.halted !== 1'b0 || bus0.imem_req !== 1'b1 || bus0.imem_addr !== 16'h0080 ||
        bus0.instr_valid !== 1'b0)
      $display("FAIL t6_redirect_wins: halted=%b req=%b addr=%h valid=%b want 0 1 0080 0",
               bus0.halted, bus0.imem_req, bus0.imem_addr, bus0.instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_pc_wrap();
    rst1 = 1'b0;
    total_cnt++;
    if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 16'hFFFE)
      $display("FAIL t5_first_req: req=%b addr=%h want 1 fffe", bus1.imem_req, bus1.imem_addr);
    else pass_cnt++;
    tick();
    bus1.imem_rvalid = 1'b1; bus1.imem_rdata = 16'h0A0A;
    tick();
    bus1.imem_rvalid = 1'b0;
    total_cnt++;
    if (bus1.instr_valid !== 1'b1 || bus1.instr_pc !== 16'hFFFE || bus1.pc_plus2 !== 16'h0000 ||
        bus1.instr !== 16'h0A0A)
      $display("FAIL t5_valid: valid=%b pc=%h pc2=%h instr=%h want 1 fffe 0000 0a0a",
               bus1.instr_valid, bus1.instr_pc, bus1.pc_plus2, bus1.instr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 16'h0000)
      $display("FAIL t5_wrap_req: req=%b addr=%h want 1 0000", bus1.imem_req, bus1.imem_addr);
    else pass_cnt++;
  endtask

  // Randomized run: every consumed instruction must be the next one in program order
  // (sequential PCs, restarting at each redirect target) with the memory image's contents.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] raddr;
    logic [15:0] prev_instr;
    logic [15:0] prev_pc;
    logic        prev_hold;
    int          cnt;
    int          n_cons;
    clear_inputs();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    exp_pc = 16'h0000; raddr = 16'h0000; cnt = 0; n_cons = 0; prev_hold = 1'b0;
    prev_instr = 16'h0000; prev_pc = 16'h0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_hold) begin
        total_cnt++;
        if (bus0.instr_valid !== 1'b1 || bus0.instr !== prev_instr || bus0.instr_pc !== prev_pc)
          $display("FAIL rand_hold c%0d: valid=%b instr=%h pc=%h want 1 %h %h", cyc,
                   bus0.instr_valid, bus0.instr, bus0.instr_pc, prev_instr, prev_pc);
        else pass_cnt++;
      end
      bus0.imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin bus0.imem_rvalid = 1'b1; bus0.imem_rdata = memf(raddr); end
      end
      bus0.instr_stall = ($urandom_range(2) == 0);
      bus0.redirect    = ($urandom_range(15) == 0);
      bus0.redirect_pc = 16'($urandom);
      if (bus0.instr_valid && !bus0.instr_stall) begin
        total_cnt++;
        if (bus0.instr_pc !== exp_pc || bus0.instr !== memf(exp_pc) ||
            bus0.pc_plus2 !== exp_pc + 16'd2)
          $display("FAIL rand_consume c%0d: pc=%h instr=%h pc2=%h want %h %h %h", cyc,
                   bus0.instr_pc, bus0.instr, bus0.pc_plus2, exp_pc, memf(exp_pc),
                   exp_pc + 16'd2);
        else pass_cnt++;
        exp_pc = exp_pc + 16'd2;
        n_cons++;
      end
      if (bus0.redirect) exp_pc = bus0.redirect_pc & 16'hFFFE;
      prev_hold  = bus0.instr_valid && bus0.instr_stall && !bus0.redirect;
      prev_instr = bus0.instr;
      prev_pc    = bus0.instr_pc;
      if (bus0.imem_req) begin
        raddr = bus0.imem_addr;
        cnt   = int'($urandom_range(3, 1));
      end
      tick();
    end
    clear_inputs();
    total_cnt++;
    if (n_cons < 100)
      $display("FAIL rand_progress: consumed=%0d want >=100", n_cons);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_halt_redirect();
    test_reset_pc_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
